// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single register-file write port between the ALU result path and the
// data-memory load path.
//
// Each producer feeds a one-entry holding buffer through a valid/ready handshake. One buffer is
// drained per cycle into a registered write port. The drain order is round-robin, except when
// both buffers target the same register: then the older entry is drained first, so writes to
// one register are never reordered.
//
// Ports:
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   alu_valid_i/ready_o  ALU handshake; alu_addr_i / alu_data_i carry the result
//   mem_valid_i/ready_o  load handshake; mem_addr_i / mem_data_i carry the result
//   rf_we_o/addr_o/data_o  registered register-file write port
//   last_grant_o         0 = ALU won the most recent grant, 1 = memory did
//   pending_o            bit i set while an accepted, unwritten result targets register i
module wb_arbiter #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned NR = 1 << AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          alu_valid_i,
    output logic          alu_ready_o,
    input  logic [AW-1:0] alu_addr_i,
    input  logic [DW-1:0] alu_data_i,
    input  logic          mem_valid_i,
    output logic          mem_ready_o,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_data_i,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_addr_o,
    output logic [DW-1:0] rf_data_o,
    output logic          last_grant_o,
    output logic [NR-1:0] pending_o
);

    logic          alu_full_q, alu_full_d;
    logic [AW-1:0] alu_addr_q, alu_addr_d;
    logic [DW-1:0] alu_data_q, alu_data_d;
    logic          mem_full_q, mem_full_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          age_q, age_d;  // 1: memory entry is older than the ALU entry
    logic          last_grant_q, last_grant_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_data_q, rf_data_d;

    logic gnt_any, gnt_to_mem, alu_gnt, mem_gnt;
    logic alu_acc, mem_acc, alu_stays, mem_stays;

    // Grant is a function of registered state only.
    always_comb begin
        gnt_any = alu_full_q | mem_full_q;
        if (alu_full_q && mem_full_q) begin
            // Same destination: oldest first, otherwise alternate.
            gnt_to_mem = (alu_addr_q == mem_addr_q) ? age_q : ~last_grant_q;
        end else begin
            gnt_to_mem = mem_full_q;
        end
        alu_gnt = alu_full_q & ~gnt_to_mem;
        mem_gnt = mem_full_q & gnt_to_mem;
    end

    // A buffer being drained this cycle can take a new entry on the same edge.
    assign alu_ready_o = ~alu_full_q | alu_gnt;
    assign mem_ready_o = ~mem_full_q | mem_gnt;
    assign alu_acc     = alu_valid_i & alu_ready_o;
    assign mem_acc     = mem_valid_i & mem_ready_o;
    assign alu_stays   = alu_full_q & ~alu_gnt;
    assign mem_stays   = mem_full_q & ~mem_gnt;

    always_comb begin
        alu_full_d   = alu_full_q;
        alu_addr_d   = alu_addr_q;
        alu_data_d   = alu_data_q;
        mem_full_d   = mem_full_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        age_d        = age_q;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;

        if (alu_gnt) alu_full_d = 1'b0;
        if (mem_gnt) mem_full_d = 1'b0;

        if (alu_acc) begin
            alu_full_d = 1'b1;
            alu_addr_d = alu_addr_i;
            alu_data_d = alu_data_i;
        end
        if (mem_acc) begin
            mem_full_d = 1'b1;
            mem_addr_d = mem_addr_i;
            mem_data_d = mem_data_i;
        end

        // Age tracks which entry arrived first; a simultaneous load counts memory as older.
        // Drain-and-reload is covered too: the entry that stays is older than the new one.
        if (alu_acc && (mem_acc || mem_stays)) begin
            age_d = 1'b1;
        end else if (mem_acc && alu_stays) begin
            age_d = 1'b0;
        end

        if (gnt_any) begin
            rf_we_d      = 1'b1;
            rf_addr_d    = gnt_to_mem ? mem_addr_q : alu_addr_q;
            rf_data_d    = gnt_to_mem ? mem_data_q : alu_data_q;
            last_grant_d = gnt_to_mem;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_full_q   <= 1'b0;
            alu_addr_q   <= '0;
            alu_data_q   <= '0;
            mem_full_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            age_q        <= 1'b0;
            last_grant_q <= 1'b1;  // ALU wins the first round-robin tie
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
        end else begin
            alu_full_q   <= alu_full_d;
            alu_addr_q   <= alu_addr_d;
            alu_data_q   <= alu_data_d;
            mem_full_q   <= mem_full_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            age_q        <= age_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_addr_o    = rf_addr_q;
    assign rf_data_o    = rf_data_q;
    assign last_grant_o = last_grant_q;

    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            pending_o[i] = (alu_full_q && (alu_addr_q == AW'(i))) ||
                           (mem_full_q && (mem_addr_q == AW'(i))) ||
                           (rf_we_q && (rf_addr_q == AW'(i)));
        end
    end

endmodule
